// File: rtl/gated_clkdiv_gate_ctrl.sv
// Gate sequencer for a gated clock divider: opens the gate on request, waits for the
// divided clock to settle before granting, and closes it after an idle timeout.
module gated_clkdiv_gate_ctrl #(
  parameter int NREQ       = 4,
  parameter int CW         = 8,
  parameter int WAKE_EDGES = 2,
  parameter int MIN_ON     = 4,
  parameter int IDLE_EDGES = 3
) (
  input  logic            CLK_IN,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic            PREEDGE,
  output logic            CLK_GATE,
  output logic [NREQ-1:0] GNT,
  output logic [1:0]      STATE,
  output logic [CW-1:0]   ACTIVE_EDGES
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    WAKE  = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_EDGES - 1);
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_EDGES - 1);

  state_t          state_r, state_nxt_s;
  logic            tick_r;
  logic            gate_r, gate_nxt_s;
  logic [NREQ-1:0] gnt_r, gnt_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [CW-1:0]   idle_r, idle_nxt_s;
  logic [CW-1:0]   active_r;
  logic            req_any_s;

  // State register, counters and registered outputs
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state_r <= OFF;
      tick_r  <= 1'b0;
      gate_r  <= 1'b0;
      gnt_r   <= '0;
      cnt_r   <= '0;
      idle_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      tick_r  <= PREEDGE;
      gate_r  <= gate_nxt_s;
      gnt_r   <= gnt_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idle_r  <= idle_nxt_s;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_nxt_s = state_r;
    gate_nxt_s  = gate_r;
    gnt_nxt_s   = '0;
    cnt_nxt_s   = cnt_r;
    idle_nxt_s  = idle_r;
    req_any_s   = |REQ;
    case (state_r)
      OFF: begin
        gate_nxt_s = 1'b0;
        if (tick_r && req_any_s) begin
          state_nxt_s = WAKE;
          gate_nxt_s  = 1'b1;
          cnt_nxt_s   = '0;
          idle_nxt_s  = '0;
        end else begin
          state_nxt_s = OFF;
        end
      end
      WAKE: begin
        gate_nxt_s = 1'b1;
        if (tick_r) begin
          if (cnt_r == WAKE_LAST) begin
            state_nxt_s = ON;
            cnt_nxt_s   = '0;
            idle_nxt_s  = '0;
          end else begin
            cnt_nxt_s = cnt_r + ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ON: begin
        gate_nxt_s = 1'b1;
        gnt_nxt_s  = REQ;
        // idle holds at its threshold so a late MIN_ON still sees it
        if (req_any_s) begin
          idle_nxt_s = '0;
        end else if (tick_r && (idle_r != IDLE_LAST)) begin
          idle_nxt_s = idle_r + ONE;
        end else begin
          idle_nxt_s = idle_r;
        end
        if (tick_r) begin
          if (!req_any_s && (idle_r == IDLE_LAST) && (cnt_r >= MIN_LAST)) begin
            state_nxt_s = DRAIN;
            cnt_nxt_s   = '0;
            idle_nxt_s  = '0;
            gnt_nxt_s   = '0;
          end else if (cnt_r != CNT_MAX) begin
            cnt_nxt_s = cnt_r + ONE;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DRAIN: begin
        gate_nxt_s = 1'b1;
        if (tick_r) begin
          cnt_nxt_s  = '0;
          idle_nxt_s = '0;
          if (req_any_s) begin
            state_nxt_s = ON;
          end else begin
            state_nxt_s = OFF;
            gate_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = OFF;
        gate_nxt_s  = 1'b0;
        cnt_nxt_s   = '0;
        idle_nxt_s  = '0;
      end
    endcase
  end

  // Saturating count of slow edges that passed through an open gate
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      active_r <= '0;
    end else if (tick_r && gate_r && (active_r != CNT_MAX)) begin
      active_r <= active_r + ONE;
    end else begin
      active_r <= active_r;
    end
  end

  assign CLK_GATE     = gate_r;
  assign GNT          = gnt_r;
  assign STATE        = state_r;
  assign ACTIVE_EDGES = active_r;

endmodule

// File: tb/tb_gated_clkdiv_gate_ctrl.sv
// Directed bench for gated_clkdiv_gate_ctrl with a divide-by-3 PREEDGE pattern;
// a second instance with CW=4 shares the stimulus to show ACTIVE_EDGES saturation.
module tb_gated_clkdiv_gate_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       pre;
  logic       gate;
  logic [3:0] gnt;
  logic [1:0] state;
  logic [7:0] ae;
  logic       gate4;
  logic [3:0] gnt4;
  logic [1:0] state4;
  logic [3:0] ae4;

  int checks = 0;
  int errors = 0;

  gated_clkdiv_gate_ctrl #(.NREQ(4), .CW(8), .WAKE_EDGES(2), .MIN_ON(4), .IDLE_EDGES(3)) dut (
    .CLK_IN(clk), .RST(rst), .REQ(req), .PREEDGE(pre),
    .CLK_GATE(gate), .GNT(gnt), .STATE(state), .ACTIVE_EDGES(ae)
  );

  gated_clkdiv_gate_ctrl #(.NREQ(4), .CW(4), .WAKE_EDGES(2), .MIN_ON(4), .IDLE_EDGES(3)) dut4 (
    .CLK_IN(clk), .RST(rst), .REQ(req), .PREEDGE(pre),
    .CLK_GATE(gate4), .GNT(gnt4), .STATE(state4), .ACTIVE_EDGES(ae4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One slow period: two plain edges, then the edge that acts on tick
  task automatic tk();
    pre = 1'b0;
    cyc();
    pre = 1'b1;
    cyc();
    pre = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    req = 4'd0;
    pre = 1'b0;
    cyc();
    cyc();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ae", {24'd0, ae}, 32'd0);
    rst = 1'b1;
    cyc();

    // wake-up latency from OFF
    req = 4'b0001;
    tk();
    chk("wake_state", {30'd0, state}, 32'd1);
    chk("wake_gate", {31'd0, gate}, 32'd1);
    chk("wake_gnt", {28'd0, gnt}, 32'd0);
    chk("wake_ae", {24'd0, ae}, 32'd0);
    tk();
    chk("wake2_state", {30'd0, state}, 32'd1);
    chk("wake2_gnt", {28'd0, gnt}, 32'd0);
    tk();
    chk("on_state", {30'd0, state}, 32'd2);
    chk("on_gnt_pre", {28'd0, gnt}, 32'd0);
    cyc();
    chk("on_gnt", {28'd0, gnt}, 32'd1);
    req = 4'b0011;
    cyc();
    chk("gnt_follow", {28'd0, gnt}, 32'd3);

    // long run: main counter exact, narrow counter saturated
    for (int i = 0; i < 18; i++) tk();
    chk("run_state", {30'd0, state}, 32'd2);
    chk("run_ae", {24'd0, ae}, 32'd20);
    chk("sat_ae4", {28'd0, ae4}, 32'd15);

    // idle shutdown
    req = 4'b0000;
    cyc();
    chk("idle_gnt", {28'd0, gnt}, 32'd0);
    tk();
    tk();
    chk("idle2_state", {30'd0, state}, 32'd2);
    tk();
    chk("drain_state", {30'd0, state}, 32'd3);
    chk("drain_gate", {31'd0, gate}, 32'd1);
    chk("drain_ae", {24'd0, ae}, 32'd23);
    tk();
    chk("off_state", {30'd0, state}, 32'd0);
    chk("off_gate", {31'd0, gate}, 32'd0);
    chk("off_ae", {24'd0, ae}, 32'd24);
    tk();
    chk("off_ae_hold", {24'd0, ae}, 32'd24);
    chk("sat_ae4_hold", {28'd0, ae4}, 32'd15);

    // one-cycle request pulse on the tick cycle: minimum on-time
    pre = 1'b0;
    cyc();
    pre = 1'b1;
    cyc();
    pre = 1'b0;
    req = 4'b0001;
    cyc();
    req = 4'b0000;
    chk("pulse_state", {30'd0, state}, 32'd1);
    tk();
    tk();
    chk("pulse_on", {30'd0, state}, 32'd2);
    tk();
    tk();
    chk("minon_t4_state", {30'd0, state}, 32'd2);
    chk("minon_gnt", {28'd0, gnt}, 32'd0);
    tk();
    chk("minon_t5_state", {30'd0, state}, 32'd2);
    tk();
    chk("minon_drain", {30'd0, state}, 32'd3);
    tk();
    chk("minon_off", {30'd0, state}, 32'd0);
    chk("minon_gate", {31'd0, gate}, 32'd0);
    chk("minon_ae", {24'd0, ae}, 32'd31);

    // re-request during DRAIN
    req = 4'b0001;
    tk();
    tk();
    tk();
    chk("rr_on", {30'd0, state}, 32'd2);
    tk();
    tk();
    tk();
    req = 4'b0000;
    tk();
    tk();
    tk();
    chk("rr_drain", {30'd0, state}, 32'd3);
    chk("rr_drain_ae", {24'd0, ae}, 32'd39);
    req = 4'b0100;
    tk();
    chk("rr_state", {30'd0, state}, 32'd2);
    chk("rr_gate", {31'd0, gate}, 32'd1);
    chk("rr_gnt_pre", {28'd0, gnt}, 32'd0);
    cyc();
    chk("rr_gnt", {28'd0, gnt}, 32'd4);

    // asynchronous reset in ON
    rst = 1'b0;
    #1;
    chk("arst_on_state", {30'd0, state}, 32'd0);
    chk("arst_on_gate", {31'd0, gate}, 32'd0);
    chk("arst_on_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_on_ae", {24'd0, ae}, 32'd0);
    rst = 1'b1;
    tk();
    chk("rewake_state", {30'd0, state}, 32'd1);
    chk("rewake_gate", {31'd0, gate}, 32'd1);

    // asynchronous reset in WAKE, then full wake sequence again
    rst = 1'b0;
    #1;
    chk("arst_wake_state", {30'd0, state}, 32'd0);
    chk("arst_wake_gate", {31'd0, gate}, 32'd0);
    rst = 1'b1;
    tk();
    chk("redo_wake", {30'd0, state}, 32'd1);
    tk();
    chk("redo_wake2", {30'd0, state}, 32'd1);
    tk();
    chk("redo_on", {30'd0, state}, 32'd2);
    chk("redo_gnt_pre", {28'd0, gnt}, 32'd0);
    chk("redo_ae", {24'd0, ae}, 32'd2);
    cyc();
    chk("redo_gnt", {28'd0, gnt}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
